// File: rtl/fifo_pkg.sv
// Shared types and elaboration-time helpers for the parametrised FIFO.
package fifo_pkg;

    // Pointer width needed to address a memory of the given depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Sticky error flags kept together so they reset and clear as a pair.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

    // Pointers wrap modulo DEPTH with no special case, so DEPTH must be a power of two.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // almost_full can never assert if its threshold exceeds the capacity.
    function automatic bit af_level_ok(input int afLevel, input int depth);
        return (afLevel >= 0) && (afLevel <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_wrEn,
    input  logic [AW-1:0]    i_wrAddr,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic [AW-1:0]    i_rdAddr,
    output logic [WIDTH-1:0] o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with selectable FWFT/registered read, thresholds and sticky errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LEVEL);

    // Reject illegal configurations while elaborating rather than misbehaving in silicon.
    if (!depth_ok(DEPTH)) begin : g_badDepth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_badAfLevel
        $error("sync_fifo_param: AF_LEVEL must not exceed DEPTH");
    end

    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    err_flags_t       r_err;
    logic             w_empty;
    logic             w_full;
    logic             w_rdAcc;
    logic             w_wrAcc;
    logic [WIDTH-1:0] w_ramData;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    // A full FIFO can still take a write when a read frees a slot on the same edge.
    assign w_rdAcc = rd_en && !w_empty;
    assign w_wrAcc = wr_en && (!w_full || w_rdAcc);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .i_clk    (clk),
        .i_wrEn   (w_wrAcc),
        .i_wrAddr (r_wrPtr),
        .i_wrData (wr_data),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_ramData)
    );

    // Advance each pointer on its accepted operation; wrap is natural modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
        end
    end

    // Occupancy moves only when exactly one of write/read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            unique case ({w_wrAcc, w_rdAcc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error bits: a new rejection wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else begin
            r_err.overflow  <= (wr_en && !w_wrAcc) || (r_err.overflow  && !clr_err);
            r_err.underflow <= (rd_en && !w_rdAcc) || (r_err.underflow && !clr_err);
        end
    end

    if (FWFT == 0) begin : g_regRead
        logic [WIDTH-1:0] r_rdData;

        // Registered read: capture the head word on each accepted pop.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdData <= '0;
            end else if (w_rdAcc) begin
                r_rdData <= w_ramData;
            end
        end

        assign rd_data = r_rdData;
    end else begin : g_fwftRead
        // Head word shown directly; forced to zero while empty so reset reads as 0.
        assign rd_data = w_empty ? '0 : w_ramData;
    end

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= AF_COUNT);
    assign almost_empty = (r_count <= AE_COUNT);
    assign count        = r_count;
    assign overflow     = r_err.overflow;
    assign underflow    = r_err.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a 16-deep registered-read FIFO driven from a vector table
// and a 4-deep FWFT FIFO driven by hand-written wrap-around and reset sequences.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst_n;

    logic       wrEn16, rdEn16, clr16;
    logic [7:0] wrData16, rdData16;
    logic       full16, empty16, af16, ae16, ov16, uf16;
    logic [4:0] count16;

    logic       wrEn4, rdEn4, clr4;
    logic [7:0] wrData4, rdData4;
    logic       full4, empty4, af4, ae4, ov4, uf4;
    logic [2:0] count4;

    int checks;
    int errors;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       uf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] q16[$];
    logic [7:0] q4[$];
    logic       mdlOv4, mdlUf4;

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)
    ) u16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn16), .wr_data(wrData16),
        .rd_en(rdEn16), .rd_data(rdData16), .full(full16), .empty(empty16),
        .almost_full(af16), .almost_empty(ae16), .count(count16),
        .overflow(ov16), .underflow(uf16), .clr_err(clr16)
    );

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)
    ) u4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn4), .wr_data(wrData4),
        .rd_en(rdEn4), .rd_data(rdData4), .full(full4), .empty(empty4),
        .almost_full(af4), .almost_empty(ae4), .count(count4),
        .overflow(ov4), .underflow(uf4), .clr_err(clr4)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected flags for the 16-deep instance follow from count and its thresholds (14, 2).
    function automatic vec_t mkVec(input logic wr, input logic [7:0] data, input logic rd,
                                   input logic clr, input int cnt, input logic ov, input logic uf);
        vec_t v;
        v.wr    = wr;
        v.data  = data;
        v.rd    = rd;
        v.clr   = clr;
        v.cnt   = cnt;
        v.full  = (cnt == 16);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 14);
        v.ae    = (cnt <= 2);
        v.ov    = ov;
        v.uf    = uf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the 16-deep FIFO: drive a vector, update the scoreboard, check after the edge.
    task automatic applyStimulus(input vec_t v);
        int         sizeBefore;
        logic       expRd;
        logic [7:0] expData;
        wrEn16     = v.wr;
        wrData16   = v.data;
        rdEn16     = v.rd;
        clr16      = v.clr;
        sizeBefore = q16.size();
        expRd      = v.rd && (sizeBefore > 0);
        expData    = 8'h00;
        if (expRd) expData = q16.pop_front();
        if (v.wr && ((sizeBefore < 16) || expRd)) q16.push_back(v.data);
        @(posedge clk);
        #1;
        checkOutput("count16", 32'(count16), 32'(v.cnt));
        checkOutput("full16", 32'(full16), 32'(v.full));
        checkOutput("empty16", 32'(empty16), 32'(v.empty));
        checkOutput("almostFull16", 32'(af16), 32'(v.af));
        checkOutput("almostEmpty16", 32'(ae16), 32'(v.ae));
        checkOutput("overflow16", 32'(ov16), 32'(v.ov));
        checkOutput("underflow16", 32'(uf16), 32'(v.uf));
        if (expRd) checkOutput("rdData16", 32'(rdData16), 32'(expData));
        wrEn16 = 1'b0;
        rdEn16 = 1'b0;
        clr16  = 1'b0;
    endtask

    // One cycle on the 4-deep FWFT FIFO, checked against the queue model and model error bits.
    task automatic stepFwft(input logic wr, input logic [7:0] data, input logic rd, input logic clr);
        int   sizeBefore;
        logic rdAcc;
        logic wrAcc;
        wrEn4      = wr;
        wrData4    = data;
        rdEn4      = rd;
        clr4       = clr;
        sizeBefore = q4.size();
        rdAcc      = rd && (sizeBefore > 0);
        wrAcc      = wr && ((sizeBefore < 4) || rdAcc);
        if (rdAcc) void'(q4.pop_front());
        if (wrAcc) q4.push_back(data);
        mdlOv4 = (wr && !wrAcc) || (mdlOv4 && !clr);
        mdlUf4 = (rd && !rdAcc) || (mdlUf4 && !clr);
        @(posedge clk);
        #1;
        checkOutput("count4", 32'(count4), 32'(q4.size()));
        checkOutput("empty4", 32'(empty4), 32'(q4.size() == 0));
        checkOutput("full4", 32'(full4), 32'(q4.size() == 4));
        checkOutput("almostFull4", 32'(af4), 32'(q4.size() >= 3));
        checkOutput("almostEmpty4", 32'(ae4), 32'(q4.size() <= 1));
        checkOutput("overflow4", 32'(ov4), 32'(mdlOv4));
        checkOutput("underflow4", 32'(uf4), 32'(mdlUf4));
        if (q4.size() > 0) checkOutput("rdData4", 32'(rdData4), 32'(q4[0]));
        wrEn4 = 1'b0;
        rdEn4 = 1'b0;
        clr4  = 1'b0;
    endtask

    // Main sequence: reset, vector table, FWFT corner cases, wrap-around stream, async reset.
    initial begin
        checks   = 0;
        errors   = 0;
        mdlOv4   = 1'b0;
        mdlUf4   = 1'b0;
        rst_n    = 1'b0;
        wrEn16   = 1'b0; rdEn16 = 1'b0; clr16 = 1'b0; wrData16 = 8'h00;
        wrEn4    = 1'b0; rdEn4  = 1'b0; clr4  = 1'b0; wrData4  = 8'h00;

        // Fill: 16 writes, count climbs to full.
        for (int i = 0; i < 16; i++) vecs.push_back(mkVec(1, 8'(i), 0, 0, i + 1, 0, 0));
        // Overflow at full, then clear it.
        vecs.push_back(mkVec(1, 8'hAA, 0, 0, 16, 1, 0));
        vecs.push_back(mkVec(0, 8'h00, 0, 1, 16, 0, 0));
        // Simultaneous write and read at full.
        vecs.push_back(mkVec(1, 8'h55, 1, 0, 16, 0, 0));
        // Drain: words 1..15 then 0x55.
        for (int k = 1; k <= 16; k++) vecs.push_back(mkVec(0, 8'h00, 1, 0, 16 - k, 0, 0));
        // Underflow at empty, then write+read at empty.
        vecs.push_back(mkVec(0, 8'h00, 1, 0, 0, 0, 1));
        vecs.push_back(mkVec(1, 8'h3C, 1, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 1, 1, 0, 0, 0));
        // Registered-read latency with 0x7E.
        vecs.push_back(mkVec(1, 8'h7E, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(0, 8'h00, 1, 0, 0, 0, 0));
        // Rejection coinciding with clear: set wins.
        vecs.push_back(mkVec(0, 8'h00, 1, 1, 0, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 0, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetCount16", 32'(count16), 32'd0);
        checkOutput("resetEmpty16", 32'(empty16), 32'd1);
        checkOutput("resetFull16", 32'(full16), 32'd0);
        checkOutput("resetAf16", 32'(af16), 32'd0);
        checkOutput("resetAe16", 32'(ae16), 32'd1);
        checkOutput("resetOv16", 32'(ov16), 32'd0);
        checkOutput("resetUf16", 32'(uf16), 32'd0);
        checkOutput("resetRdData16", 32'(rdData16), 32'd0);
        checkOutput("resetRdData4", 32'(rdData4), 32'd0);
        checkOutput("resetEmpty4", 32'(empty4), 32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // FWFT: word visible the cycle after the write, without rd_en.
        stepFwft(1, 8'h7E, 0, 0);
        checkOutput("fwftFirstWord", 32'(rdData4), 32'h7E);
        stepFwft(0, 8'h00, 1, 0);

        // Wrap-around: hold occupancy at 2 while streaming 0..39 through 4 entries.
        stepFwft(1, 8'd0, 0, 0);
        stepFwft(1, 8'd1, 0, 0);
        for (int k = 2; k < 40; k++) stepFwft(1, 8'(k), 1, 0);
        stepFwft(0, 8'h00, 1, 0);
        stepFwft(0, 8'h00, 1, 0);

        // Asynchronous reset mid-stream: state clears before any clock edge.
        stepFwft(1, 8'hA1, 0, 0);
        stepFwft(1, 8'hA2, 0, 0);
        applyStimulus(mkVec(1, 8'h11, 0, 0, 1, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncCount4", 32'(count4), 32'd0);
        checkOutput("asyncEmpty4", 32'(empty4), 32'd1);
        checkOutput("asyncCount16", 32'(count16), 32'd0);
        checkOutput("asyncEmpty16", 32'(empty16), 32'd1);
        checkOutput("asyncRdData16", 32'(rdData16), 32'd0);
        q4.delete();
        q16.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
